gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 91 +++++++++
 tb/tb_gshare_predictor.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare/bimodal 2^IDX_W-entry counter table with init sweep, speculative GHR and mispredict recovery
module gshare_predictor #(
  parameter int IDX_W  = 8,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 8,
  parameter int MODE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [IDX_W-1:0]  lookup_index,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic              ready,
  output logic [15:0]       mispred_count
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] WEAK = CNT_W'((1 << (CNT_W - 1)) - 1);
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0]  r_tbl [DEPTH];
  logic [IDX_W-1:0]  r_ptr;
  logic [HIST_W-1:0] r_ghr, r_ph;
  logic [15:0]       r_mcnt;
  logic              r_pv, r_pt;
  logic [IDX_W-1:0]  w_lidx, w_uidx;
  logic [CNT_W-1:0]  w_cur, w_new;
  logic              w_run, w_pred;
  logic [HIST_W-1:0] w_spec, w_rest;
  function automatic logic [IDX_W-1:0] eff(input logic [IDX_W-1:0] idx, input logic [HIST_W-1:0] h);
    return (MODE != 0) ? idx ^ IDX_W'(h) : idx;
  endfunction
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= INIT;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == INIT && r_ptr == IDX_W'(DEPTH - 1)) ? RUN : r_state;
  end
  always_comb begin
    w_run = (r_state == RUN);
    ready = w_run;
  end
  assign w_lidx = eff(lookup_index, r_ghr);
  assign w_uidx = eff(upd_index, upd_hist);
  assign w_pred = r_tbl[w_lidx][CNT_W-1];
  assign w_cur  = r_tbl[w_uidx];
  assign w_new  = upd_taken ? ((&w_cur) ? w_cur : w_cur + CNT_W'(1))
                            : ((|w_cur) ? w_cur - CNT_W'(1) : w_cur);
  // Taking the low HIST_W bits of the concatenation keeps HIST_W=1 legal
  assign w_spec = HIST_W'({r_ghr, w_pred});
  assign w_rest = HIST_W'({upd_hist, upd_taken});
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_ghr  <= '0;
      r_mcnt <= '0;
      r_pv   <= 1'b0;
      r_pt   <= 1'b0;
      r_ph   <= '0;
    end else begin
      r_pv <= w_run && lookup_valid;
      if (!w_run) begin
        r_tbl[r_ptr] <= WEAK;
        r_ptr        <= r_ptr + IDX_W'(1);
      end else begin
        if (lookup_valid) begin
          r_pt <= w_pred;
          r_ph <= r_ghr;
        end
        if (upd_valid) r_tbl[w_uidx] <= w_new;
        if (upd_valid && upd_mispredict) begin
          r_ghr  <= w_rest;
          r_mcnt <= (&r_mcnt) ? r_mcnt : r_mcnt + 16'd1;
        end else if (lookup_valid) begin
          r_ghr <= w_spec;
        end
      end
    end
  end
  assign pred_valid    = r_pv;
  assign pred_taken    = r_pt;
  assign pred_hist     = r_ph;
  assign mispred_count = r_mcnt;
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: random and directed stimulus checked against an integer reference model of the predictor
module tb_gshare_predictor;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        lookup_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, upd_mispredict = 1'b0;
  logic [7:0]  lookup_index = '0, upd_index = '0, upd_hist = '0;
  logic        pred_valid, pred_taken, ready;
  logic [7:0]  pred_hist;
  logic [15:0] mispred_count;
  int n_chk = 0, n_fail = 0;
  int tbl [256];
  int ghr, mcnt, init_left, e_ph;
  bit e_pv, e_pt;

  always #5 clk = ~clk;

  gshare_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .ready(ready), .mispred_count(mispred_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    upd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    ghr = 0; mcnt = 0; init_left = 256; e_pt = 0; e_ph = 0;
    foreach (tbl[i]) tbl[i] = 1;
    check("rst_pv", pred_valid, 0);
    check("rst_pt", pred_taken, 0);
    check("rst_ph", pred_hist, 0);
    check("rst_ready", ready, 0);
    check("rst_mcnt", mispred_count, 0);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit lv, input int li, input bit uv, input int ui, input int uh,
                      input bit ut, input bit um);
    bit p;
    int k;
    lookup_valid = lv; lookup_index = li[7:0];
    upd_valid = uv; upd_index = ui[7:0]; upd_hist = uh[7:0];
    upd_taken = ut; upd_mispredict = um;
    e_pv = 0;
    if (init_left > 0) init_left--;
    else begin
      e_pv = lv;
      p = tbl[(li ^ ghr) & 255] >= 2;
      if (lv) begin e_pt = p; e_ph = ghr; end
      if (uv) begin
        k = (ui ^ uh) & 255;
        tbl[k] = ut ? (tbl[k] < 3 ? tbl[k] + 1 : 3) : (tbl[k] > 0 ? tbl[k] - 1 : 0);
      end
      if (uv && um) begin
        ghr = ((uh << 1) | int'(ut)) & 255;
        if (mcnt < 65535) mcnt++;
      end else if (lv) ghr = ((ghr << 1) | int'(p)) & 255;
    end
    @(posedge clk);
    #1;
    check("pv", pred_valid, e_pv);
    if (e_pv) begin
      check("pt", pred_taken, e_pt);
      check("ph", pred_hist, e_ph);
    end
    check("ready", ready, init_left == 0);
    check("mcnt", mispred_count, mcnt);
  endtask

  task automatic rnd_step(input bit in_init);
    step($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1),
         $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
         in_init ? 1'b1 : ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    do_reset(2);
    repeat (256) rnd_step(1);
    repeat (3) step(1, 8'h20, 0, 0, 0, 0, 0);
    check("hist0", pred_hist, 8'h00);
    repeat (2) step(0, 0, 1, 8'h0F, 0, 1, 0);
    step(1, 8'h0F, 0, 0, 0, 0, 0);
    check("hist_pt", pred_taken, 1);
    check("hist_ph", pred_hist, 8'h00);
    step(1, 8'h33, 0, 0, 0, 0, 0);
    check("hist_ph1", pred_hist, 8'h01);
    repeat (4) step(0, 0, 1, 5, 0, 1, 0);
    step(1, 5 ^ ghr, 0, 0, 0, 0, 0);
    check("sat_max", pred_taken, 1);
    step(0, 0, 1, 5, 0, 0, 0);
    step(1, 5 ^ ghr, 0, 0, 0, 0, 0);
    check("sat_nt1", pred_taken, 1);
    repeat (2) step(0, 0, 1, 5, 0, 0, 0);
    step(1, 5 ^ ghr, 0, 0, 0, 0, 0);
    check("sat_nt3", pred_taken, 0);
    repeat (5) step(0, 0, 1, 5, 0, 0, 0);
    step(0, 0, 1, 5, 0, 1, 0);
    step(0, 0, 1, 5, 0, 1, 0);
    step(1, 5 ^ ghr, 0, 0, 0, 0, 0);
    check("sat_floor", pred_taken, 1);
    step(0, 0, 1, 0, 8'h2A, 1, 1);
    step(1, 3, 1, 7, 8'h12, 1, 1);
    check("rec_ph", pred_hist, 8'h55);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rec_ghr", pred_hist, 8'h25);
    check("rec_mcnt", mispred_count, 2);
    repeat (2000) rnd_step(0);
    do_reset(2);
    repeat (256) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 9, 1, 9, 0, 1, 0);
    check("coll_pre", pred_taken, 0);
    step(1, 9 ^ ghr, 0, 0, 0, 0, 0);
    check("coll_post", pred_taken, 1);
    do_reset(2);
    repeat (100) rnd_step(1);
    do_reset(2);
    repeat (255) rnd_step(1);
    check("sweep_255", ready, 0);
    rnd_step(1);
    check("sweep_256", ready, 1);
    repeat (65540) step(0, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 1);
    check("mcnt_sat", mispred_count, 16'hFFFF);
    step(1, 0, 1, 1, 2, 1, 1);
    check("mcnt_hold", mispred_count, 16'hFFFF);
    do_reset(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
